sr_tcam_writer: RTL and testbench

- Rule-update engine for the SRAM-based ternary CAM. The CAM holds 72 blocks; each block is 4 rows x 256 columns, indexed by one 2-bit key slice.
- The writer accepts one ternary rule (144-bit value, 144-bit care-mask, entry index 0..255) and rewrites that entry's column in every block, one block per clock.
- It sits between the control/software interface and the CAM memory write ports. Lookups stay combinational.

---
 rtl/sr_tcam_pkg.sv | 20 ++
 rtl/sr_tcam_rowgen.sv | 21 ++
 rtl/sr_tcam_writer.sv | 103 ++++++++++
 tb/tb_sr_tcam_writer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/sr_tcam_pkg.sv
// Shared constants, op encodings and FSM state type for the TCAM rule writer.
package sr_tcam_pkg;

    localparam int unsigned KEY_W   = 144;
    localparam int unsigned ENTRIES = 256;
    localparam int unsigned ENT_W   = 8;
    localparam int unsigned NUM_BLK = KEY_W / 2;
    localparam int unsigned BLK_W   = 7;
    localparam int unsigned IDX_W   = BLK_W + 1;

    localparam logic OP_INSERT = 1'b0;
    localparam logic OP_DELETE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/sr_tcam_rowgen.sv
// Maps one 2-bit ternary slice (value, care-mask) to the 4 row bits of its block column.
module sr_tcam_rowgen
    import sr_tcam_pkg::*;
(
    input  logic       op,
    input  logic [1:0] v,
    input  logic [1:0] m,
    output logic [3:0] bits_c
);

    // Row r matches when it agrees with v on every cared-for bit; delete clears all rows.
    always_comb begin
        bits_c = 4'b0000;
        if (op == OP_INSERT) begin
            for (int r = 0; r < 4; r++) begin
                bits_c[r] = (((2'(r) ^ v) & m) == 2'b00);
            end
        end
    end

endmodule

// File: rtl/sr_tcam_writer.sv
// Rule-update engine: rewrites one entry column across all 72 CAM blocks, one block per clock.
module sr_tcam_writer
    import sr_tcam_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic               wr_op,
    input  logic [ENT_W-1:0]   wr_entry,
    input  logic [KEY_W-1:0]   wr_value,
    input  logic [KEY_W-1:0]   wr_mask,
    output logic               mem_we,
    output logic [BLK_W-1:0]   mem_blk,
    output logic [ENT_W-1:0]   mem_col,
    output logic [3:0]         mem_bits,
    output logic               busy,
    output logic               done
);

    state_t             state, state_n;
    logic [BLK_W-1:0]   cnt, cnt_n;
    logic               op_q, op_n;
    logic [ENT_W-1:0]   entry_q, entry_n;
    logic [KEY_W-1:0]   value_q, value_n;
    logic [KEY_W-1:0]   mask_q, mask_n;
    logic [IDX_W-1:0]   base;
    logic [3:0]         bits_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_n;
    end

    // Next state, block counter and request latch; inputs only sampled when accepted in IDLE.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        op_n    = op_q;
        entry_n = entry_q;
        value_n = value_q;
        mask_n  = mask_q;
        unique case (state)
            ST_IDLE: begin
                if (wr_valid && wr_ready) begin
                    op_n    = wr_op;
                    entry_n = wr_entry;
                    value_n = wr_value;
                    mask_n  = wr_mask;
                    cnt_n   = '0;
                    state_n = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (cnt == BLK_W'(NUM_BLK - 1)) state_n = ST_DONE;
                else                            cnt_n   = cnt + BLK_W'(1);
            end
            ST_DONE:  state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    // Row bits are generated for the block that will be on the bus next cycle.
    assign base = {cnt_n, 1'b0};

    sr_tcam_rowgen u_rowgen (
        .op     (op_n),
        .v      (value_n[base +: 2]),
        .m      (mask_n[base +: 2]),
        .bits_c (bits_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            op_q     <= OP_INSERT;
            entry_q  <= '0;
            value_q  <= '0;
            mask_q   <= '0;
            wr_ready <= 1'b1;
            mem_we   <= 1'b0;
            mem_blk  <= '0;
            mem_col  <= '0;
            mem_bits <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            cnt      <= cnt_n;
            op_q     <= op_n;
            entry_q  <= entry_n;
            value_q  <= value_n;
            mask_q   <= mask_n;
            wr_ready <= (state_n == ST_IDLE);
            mem_we   <= (state_n == ST_WRITE);
            mem_blk  <= cnt_n;
            mem_col  <= entry_n;
            mem_bits <= (state_n == ST_WRITE) ? bits_c : 4'b0000;
            busy     <= (state_n == ST_WRITE);
            done     <= (state_n == ST_DONE);
        end
    end

endmodule

// File: tb/tb_sr_tcam_writer.sv
// Directed bench for sr_tcam_writer: write scoreboard, latency checks and a CAM lookup model.
module tb_sr_tcam_writer;
    import sr_tcam_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               wr_valid = 1'b0;
    logic               wr_ready;
    logic               wr_op = 1'b0;
    logic [ENT_W-1:0]   wr_entry = '0;
    logic [KEY_W-1:0]   wr_value = '0;
    logic [KEY_W-1:0]   wr_mask = '0;
    logic               mem_we;
    logic [BLK_W-1:0]   mem_blk;
    logic [ENT_W-1:0]   mem_col;
    logic [3:0]         mem_bits;
    logic               busy;
    logic               done;

    sr_tcam_writer dut (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_op(wr_op), .wr_entry(wr_entry), .wr_value(wr_value), .wr_mask(wr_mask),
        .mem_we(mem_we), .mem_blk(mem_blk), .mem_col(mem_col), .mem_bits(mem_bits),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [BLK_W-1:0] blk;
        logic [ENT_W-1:0] col;
        logic [3:0]       bits;
    } wr_t;

    wr_t        sb[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         n_writes = 0;
    logic [3:0] cam [NUM_BLK][ENTRIES];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Independent row model: a row matches if it equals v on every cared-for bit.
    function automatic logic [3:0] exp_bits(input logic op, input logic [1:0] v, input logic [1:0] m);
        logic [3:0] b;
        logic [1:0] rr;
        b = 4'b0000;
        if (op == OP_INSERT) begin
            for (int r = 0; r < 4; r++) begin
                rr = 2'(r);
                b[r] = (!m[1] || (rr[1] == v[1])) && (!m[0] || (rr[0] == v[0]));
            end
        end
        return b;
    endfunction

    function automatic logic lookup(input logic [KEY_W-1:0] addr, input int e);
        logic hit;
        hit = 1'b1;
        for (int k = 0; k < NUM_BLK; k++) hit = hit & cam[k][e][addr[2*k +: 2]];
        return hit;
    endfunction

    task automatic push_req(input logic op, input logic [ENT_W-1:0] entry,
                            input logic [KEY_W-1:0] value, input logic [KEY_W-1:0] mask);
        for (int k = 0; k < NUM_BLK; k++)
            sb.push_back('{BLK_W'(k), entry, exp_bits(op, value[2*k +: 2], mask[2*k +: 2])});
    endtask

    // Memory-port monitor: updates the CAM model and checks each write against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && mem_we === 1'b1) begin
            wr_t e;
            n_writes++;
            cam[mem_blk][mem_col] = mem_bits;
            if (sb.size() == 0) chk("unexpected_write", 32'(mem_blk), 32'hFFFF);
            else begin
                e = sb.pop_front();
                chk("mem_blk", 32'(mem_blk), 32'(e.blk));
                chk("mem_col", 32'(mem_col), 32'(e.col));
                chk("mem_bits", 32'(mem_bits), 32'(e.bits));
            end
        end
    end

    task automatic send(input logic op, input logic [ENT_W-1:0] entry,
                        input logic [KEY_W-1:0] value, input logic [KEY_W-1:0] mask,
                        input bit keep_valid, output int acc);
        int t;
        t = 0;
        @(negedge clk);
        while (wr_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("ready_wait", 32'(wr_ready), 32'h1);
        wr_valid = 1'b1; wr_op = op; wr_entry = entry; wr_value = value; wr_mask = mask;
        push_req(op, entry, value, mask);
        @(posedge clk);
        #1 acc = cyc;
        if (!keep_valid) wr_valid = 1'b0;
    endtask

    task automatic wait_done(input int acc, input string tag);
        int t;
        t = 0;
        @(negedge clk);
        while (done !== 1'b1 && t < 150) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_done_lat"}, 32'(cyc - acc), 32'd72);
        chk({tag, "_done_busy"}, {30'd0, busy, mem_we}, 32'h0);
        chk({tag, "_sb_drained"}, 32'(sb.size()), 32'h0);
        @(negedge clk);
        chk({tag, "_ready_back"}, {31'd0, wr_ready}, 32'h1);
        chk({tag, "_done_width"}, {31'd0, done}, 32'h0);
    endtask

    logic [KEY_W-1:0] ones, v, m, addr, v2, m2;
    int acc, acc2, t;

    initial begin
        ones = '1;
        for (int k = 0; k < NUM_BLK; k++)
            for (int e = 0; e < ENTRIES; e++) cam[k][e] = 4'b0000;

        #12;
        chk("rst_ready", {31'd0, wr_ready}, 32'h1);
        chk("rst_we_busy_done", {29'd0, mem_we, busy, done}, 32'h0);
        chk("rst_mem", {13'd0, mem_blk, mem_col, mem_bits}, 32'h0);
        @(negedge clk) rst_n = 1'b1;

        // Exact-match insert of value 0
        send(OP_INSERT, 8'd5, '0, ones, 1'b0, acc);
        @(negedge clk);
        chk("t1_first_write", {23'd0, mem_we, busy, wr_ready, mem_blk}, {23'd0, 1'b1, 1'b1, 1'b0, 7'd0});
        chk("t1_bits", 32'(mem_bits), 32'h1);
        wait_done(acc, "t1");
        chk("t1_nwrites", 32'(n_writes), 32'd72);

        // Wildcard low slice on the last entry
        v = '0; v[1:0] = 2'b10;
        m = ones; m[1:0] = 2'b00;
        send(OP_INSERT, 8'd255, v, m, 1'b0, acc);
        wait_done(acc, "t2");
        chk("t2_blk0", 32'(cam[0][255]), 32'hF);
        chk("t2_blk5", 32'(cam[5][255]), 32'h1);
        addr = 144'h3;
        chk("t2_lookup", {31'd0, lookup(addr, 255)}, 32'h1);

        // Half-mask on block 1
        v = '0; v[3:2] = 2'b11;
        m = ones; m[3:2] = 2'b01;
        send(OP_INSERT, 8'd0, v, m, 1'b0, acc);
        wait_done(acc, "t3");
        chk("t3_blk1", 32'(cam[1][0]), 32'hA);
        addr = '0; addr[3:2] = 2'b01;
        chk("t3_hit", {31'd0, lookup(addr, 0)}, 32'h1);
        addr[3:2] = 2'b00;
        chk("t3_miss", {31'd0, lookup(addr, 0)}, 32'h0);

        // Back-to-back: valid held with new data while the first update runs
        send(OP_INSERT, 8'd17, '0, '0, 1'b1, acc);
        v2 = 144'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
        m2 = 144'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
        wr_entry = 8'd40; wr_value = v2; wr_mask = m2; wr_op = OP_INSERT;
        push_req(OP_INSERT, 8'd40, v2, m2);
        while (cyc - acc < 73) @(negedge clk);
        chk("t5_ready_n74", {31'd0, wr_ready}, 32'h1);
        @(posedge clk);
        #1 acc2 = cyc;
        wr_valid = 1'b0;
        chk("t5_accept_gap", 32'(acc2 - acc), 32'd74);
        wait_done(acc2, "t5");
        addr = 144'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
        chk("t5_wild17", {31'd0, lookup(addr, 17)}, 32'h1);
        addr = v2;
        chk("t5_self40", {31'd0, lookup(addr, 40)}, 32'h1);

        // Delete of the wildcard entry
        send(OP_DELETE, 8'd17, ones, ones, 1'b0, acc);
        wait_done(acc, "t4");
        for (int i = 0; i < 3; i++) begin
            addr = 144'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
            chk("t4_del17", {31'd0, lookup(addr, 17)}, 32'h0);
        end

        // Reset in the middle of a write sweep
        send(OP_INSERT, 8'd99, '0, ones, 1'b0, acc);
        t = 0;
        while (mem_blk !== 7'd30 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("t6_reach30", 32'(mem_blk), 32'd30);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_clear", {28'd0, mem_we, busy, done, wr_ready}, 32'h1);
        sb.delete();
        @(negedge clk) rst_n = 1'b1;
        n_writes = 0;
        send(OP_INSERT, 8'd77, '0, ones, 1'b0, acc);
        @(negedge clk);
        chk("t6_restart_blk", {24'd0, mem_we, mem_blk}, {24'd0, 1'b1, 7'd0});
        wait_done(acc, "t6");
        chk("t6_nwrites", 32'(n_writes), 32'd72);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
